// File: rtl/elevator_pkg.sv
// Shared types and helpers for the single-car elevator floor controller.
package elevator_pkg;

  localparam int N_FLOORS = 8;
  localparam int FLOOR_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DOOR   = 2'd2
  } state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Floors strictly beyond f in direction d; empty past the top/bottom floor,
  // which is what keeps floor_bin from ever wrapping.
  function automatic logic [N_FLOORS-1:0] ahead_mask(input logic [FLOOR_W-1:0] f,
                                                     input dir_e d);
    logic [N_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < N_FLOORS; i++) begin
      if (d == DIR_UP) m[i] = (i > int'(f));
      else             m[i] = (i < int'(f));
    end
    return m;
  endfunction

endpackage

// File: rtl/elevator_timer.sv
// Wrapping cycle counter 0..TC-1; done marks the enabled terminal-count cycle.
module elevator_timer #(
  parameter int unsigned TC = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_done
);

  localparam int W = (TC > 1) ? $clog2(TC) : 1;
  localparam logic [W-1:0] LAST = W'(TC - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || i_clear)  r_cnt <= '0;
    else if (i_enable)     r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  assign o_done = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/elevator_floor_ctrl.sv
// Elevator floor controller: request register, IDLE/MOVING/DOOR_OPEN FSM with
// collective-in-direction scheduling, travel and door timers.
module elevator_floor_ctrl import elevator_pkg::*; #(
  parameter int unsigned TRAVEL_CYCLES = 50_000_000,
  parameter int unsigned DOOR_CYCLES   = 150_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_FLOORS-1:0] call_btn,
  input  logic                overload,
  output logic [FLOOR_W-1:0]  floor_bin,
  output logic                moving_up,
  output logic                moving_down,
  output logic                door_open,
  output logic [N_FLOORS-1:0] pending
);

  state_e              r_state, w_state_nxt;
  dir_e                r_dir, w_dir_nxt;
  logic [FLOOR_W-1:0]  r_floor, w_floor_nxt, w_new_floor;
  logic [N_FLOORS-1:0] r_pending, w_clr;
  logic                w_door_rst;
  logic                w_travel_done, w_door_done;

  elevator_timer #(.TC(TRAVEL_CYCLES)) u_travel_tmr (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (r_state != ST_MOVING),
    .i_enable (r_state == ST_MOVING),
    .o_done   (w_travel_done)
  );

  // Overload and a same-floor call both pin the door count at zero.
  elevator_timer #(.TC(DOOR_CYCLES)) u_door_tmr (
    .clk      (clk),
    .reset    (reset),
    .i_clear  ((r_state != ST_DOOR) || overload || w_door_rst),
    .i_enable ((r_state == ST_DOOR) && !overload),
    .o_done   (w_door_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_dir     <= DIR_UP;
      r_floor   <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_floor   <= w_floor_nxt;
      r_pending <= (r_pending | call_btn) & ~w_clr;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir;
    w_floor_nxt = r_floor;
    w_clr       = '0;
    w_door_rst  = 1'b0;
    w_new_floor = (r_dir == DIR_UP) ? r_floor + 1'b1 : r_floor - 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (r_pending[r_floor]) begin
          w_clr[r_floor] = 1'b1;
          w_state_nxt    = ST_DOOR;
        end else if ((r_pending & ahead_mask(r_floor, r_dir)) != '0) begin
          w_state_nxt = ST_MOVING;
        end else if (r_pending != '0) begin
          w_dir_nxt   = (r_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
          w_state_nxt = ST_MOVING;
        end
      end
      ST_MOVING: begin
        if (w_travel_done) begin
          w_floor_nxt = w_new_floor;
          if (r_pending[w_new_floor]) begin
            w_clr[w_new_floor] = 1'b1;
            w_state_nxt        = ST_DOOR;
          end else if ((r_pending & ahead_mask(w_new_floor, r_dir)) == '0) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DOOR: begin
        if (r_pending[r_floor]) begin
          w_clr[r_floor] = 1'b1;
          w_door_rst     = 1'b1;
        end else if (w_door_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    floor_bin   = r_floor;
    pending     = r_pending;
    moving_up   = (r_state == ST_MOVING) && (r_dir == DIR_UP);
    moving_down = (r_state == ST_MOVING) && (r_dir == DIR_DOWN);
    door_open   = (r_state == ST_DOOR);
  end

endmodule

// File: tb/tb_elevator_floor_ctrl.sv
// Directed bench for elevator_floor_ctrl with TRAVEL_CYCLES=4, DOOR_CYCLES=3.
module tb_elevator_floor_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] call_btn = 8'h00;
  logic       overload = 1'b0;
  logic [2:0] floor_bin;
  logic       moving_up, moving_down, door_open;
  logic [7:0] pending;

  int checks = 0;
  int failures = 0;

  elevator_floor_ctrl #(.TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .call_btn    (call_btn),
    .overload    (overload),
    .floor_bin   (floor_bin),
    .moving_up   (moving_up),
    .moving_down (moving_down),
    .door_open   (door_open),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] call;
    logic       ovl;
    logic [2:0] flr;
    logic       up;
    logic       dn;
    logic       door;
    logic [7:0] pend;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic [7:0] call, input logic ovl,
                     input logic [2:0] flr, input logic up, input logic dn,
                     input logic door, input logic [7:0] pend);
    vec_t v;
    v.rst = rst; v.call = call; v.ovl = ovl; v.flr = flr;
    v.up = up; v.dn = dn; v.door = door; v.pend = pend;
    vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; call_btn = 8'h00; overload = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic press(input logic [7:0] m);
    call_btn = m;
    step();
    call_btn = 8'h00;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return door_open;
      1:       return moving_up;
      default: return moving_down;
    endcase
  endfunction

  task automatic wait_sig(input string nm, input int w, input logic val, input int bound);
    int n = 0;
    while (sel(w) !== val && n < bound) begin
      step();
      n++;
    end
    chk(nm, 32'(sel(w)), 32'(val));
  endtask

  task automatic wait_floor(input string nm, input logic [2:0] f, input int bound);
    int n = 0;
    while (floor_bin !== f && n < bound) begin
      step();
      n++;
    end
    chk(nm, 32'(floor_bin), 32'(f));
  endtask

  initial begin
    int cnt;
    logic [7:0] pm;

    // Door-only service at floor 0: no motion at any point.
    add(1, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    add(0, 8'h01, 0, 0, 0, 0, 0, 8'h01);
    for (int k = 0; k < 3; k++) add(0, 8'h00, 0, 0, 0, 0, 1, 8'h00);
    add(0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    add(0, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    // Single trip 0 -> 3: four cycles per floor, three door cycles.
    add(1, 8'h00, 0, 0, 0, 0, 0, 8'h00);
    add(0, 8'h08, 0, 0, 0, 0, 0, 8'h08);
    for (int f = 0; f < 3; f++)
      for (int k = 0; k < 4; k++) add(0, 8'h00, 0, 3'(f), 1, 0, 0, 8'h08);
    for (int k = 0; k < 3; k++) add(0, 8'h00, 0, 3, 0, 0, 1, 8'h00);
    add(0, 8'h00, 0, 3, 0, 0, 0, 8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst; call_btn = vecs[i].call; overload = vecs[i].ovl;
      step();
      chk($sformatf("vec%0d floor", i), 32'(floor_bin), 32'(vecs[i].flr));
      chk($sformatf("vec%0d up", i), 32'(moving_up), 32'(vecs[i].up));
      chk($sformatf("vec%0d down", i), 32'(moving_down), 32'(vecs[i].dn));
      chk($sformatf("vec%0d door", i), 32'(door_open), 32'(vecs[i].door));
      chk($sformatf("vec%0d pending", i), 32'(pending), 32'(vecs[i].pend));
    end

    // Calls at 4 and 1 while travelling 2 -> 6: serve 4, 6, then reverse to 1.
    do_reset();
    press(8'h40);
    wait_floor("s027 reach2", 3'd2, 60);
    press(8'h12);
    wait_sig("s027 door4", 0, 1'b1, 60);
    chk("s027 floor4", 32'(floor_bin), 32'd4);
    chk("s027 pend4", 32'(pending), 32'h42);
    wait_sig("s027 close4", 0, 1'b0, 20);
    wait_sig("s027 door6", 0, 1'b1, 60);
    chk("s027 floor6", 32'(floor_bin), 32'd6);
    chk("s027 pend6", 32'(pending), 32'h02);
    wait_sig("s027 down", 2, 1'b1, 20);
    chk("s027 down from6", 32'(floor_bin), 32'd6);
    wait_sig("s027 door1", 0, 1'b1, 80);
    chk("s027 floor1", 32'(floor_bin), 32'd1);
    chk("s027 pend1", 32'(pending), 32'h00);

    // Overload hold at floor 5: 10 held cycles plus 3 counted cycles.
    do_reset();
    press(8'h20);
    wait_sig("s028 door5", 0, 1'b1, 80);
    chk("s028 floor5", 32'(floor_bin), 32'd5);
    cnt = 1;
    overload = 1'b1;
    repeat (10) begin
      step();
      if (door_open) cnt++;
    end
    overload = 1'b0;
    for (int n = 0; n < 20 && door_open; n++) begin
      step();
      if (door_open) cnt++;
    end
    chk("s028 ovl door cycles", 32'(cnt), 32'd13);
    // Same-floor call registered mid-door restarts the count: 2 + 1 + 3 cycles.
    press(8'h20);
    step();
    chk("s028 reopen", 32'(door_open), 32'd1);
    cnt = 1;
    step();
    if (door_open) cnt++;
    call_btn = 8'h20;
    step();
    if (door_open) cnt++;
    call_btn = 8'h00;
    for (int n = 0; n < 20 && door_open; n++) begin
      step();
      if (door_open) cnt++;
    end
    chk("s028 restart door cycles", 32'(cnt), 32'd6);
    chk("s028 pend after", 32'(pending), 32'h00);

    // Reset mid-travel between 4 and 5 with requests outstanding.
    do_reset();
    press(8'h80);
    wait_floor("s029 reach4", 3'd4, 60);
    press(8'h01);
    chk("s029 pend81", 32'(pending), 32'h81);
    chk("s029 midtravel", 32'({moving_up, floor_bin}), 32'({1'b1, 3'd4}));
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("s029 floor", 32'(floor_bin), 32'd0);
    chk("s029 status", 32'({moving_up, moving_down, door_open}), 32'd0);
    chk("s029 pend", 32'(pending), 32'h00);
    step();
    chk("s029 stays idle", 32'({moving_up, moving_down, door_open, floor_bin}), 32'd0);

    // All floors called at once from 0: served strictly upward, stop at 7.
    do_reset();
    press(8'hFF);
    step();
    chk("s030 door0", 32'({door_open, floor_bin}), 32'({1'b1, 3'd0}));
    chk("s030 pend0", 32'(pending), 32'hFE);
    for (int k = 1; k < 8; k++) begin
      wait_sig($sformatf("s030 close%0d", k - 1), 0, 1'b0, 20);
      wait_sig($sformatf("s030 door%0d", k), 0, 1'b1, 40);
      chk($sformatf("s030 floor%0d", k), 32'(floor_bin), 32'(k));
      pm = 8'hFF;
      pm = pm << (k + 1);
      chk($sformatf("s030 pend%0d", k), 32'(pending), 32'(pm));
    end
    wait_sig("s030 close7", 0, 1'b0, 20);
    repeat (5) step();
    chk("s030 rest at 7", 32'({moving_up, moving_down, door_open, floor_bin}), 32'({3'b000, 3'd7}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_floor_ctrl.md
ELEVATOR_FLOOR_CTRL -- requirements
Module: elevator_floor_ctrl

Interface
REQ-001 SHALL have parameter TRAVEL_CYCLES, default 50_000_000, clock cycles per one-floor move (>=1).
REQ-002 SHALL have parameter DOOR_CYCLES, default 150_000_000, clock cycles the door stays open (>=1).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port call_btn, input, 8, one bit per floor 0..7; a high level for any cycle registers a request.
REQ-006 SHALL have port overload, input, 1, max-load sensor; high holds the door open.
REQ-007 SHALL have port floor_bin, output, 3, current floor in binary; drives the downstream 7-segment decoder directly.
REQ-008 SHALL have port moving_up, output, 1, high while in MOVING with direction up.
REQ-009 SHALL have port moving_down, output, 1, high while in MOVING with direction down.
REQ-010 SHALL have port door_open, output, 1, high exactly while in DOOR_OPEN.
REQ-011 SHALL have port pending, output, 8, registered request vector.

Function
REQ-012 SHALL implement states IDLE, MOVING, DOOR_OPEN, plus a direction register dir (UP/DOWN).
REQ-013 pending SHALL update each edge as pending | call_btn, minus any bit cleared that edge; clear wins over a same-cycle set of the same bit.
REQ-014 All decisions SHALL use the registered pending only (request-to-action latency one cycle minimum).
REQ-015 IDLE: if pending[floor] -> clear it, enter DOOR_OPEN; else if requests ahead in dir -> MOVING; else if requests behind -> flip dir, MOVING; else stay IDLE.
REQ-016 MOVING: travel timer counts 0..TRAVEL_CYCLES-1; on the edge at TRAVEL_CYCLES-1, floor_bin steps +1 (UP) or -1 (DOWN) and timer returns to 0.
REQ-017 On that same arrival edge: if pending[new floor] -> clear it, enter DOOR_OPEN; else if requests beyond new floor in dir -> stay MOVING; else -> IDLE.
REQ-018 floor_bin SHALL never wrap: MOVING UP is only entered/kept with a request above, DOWN with one below; 7 and 0 are hard limits.
REQ-019 DOOR_OPEN: door timer counts 0..DOOR_CYCLES-1, then -> IDLE; while overload is high the timer is held at 0.
REQ-020 A call at the current floor during DOOR_OPEN SHALL clear that bit and restart the door timer at 0.
REQ-021 dir SHALL change only in IDLE (REQ-015).

Reset
REQ-022 On reset: state IDLE, floor_bin 3'd0, dir UP, pending 8'h00, both timers 0, moving_up/moving_down/door_open 0; overrides any operation in progress, including mid-travel.

Structure
REQ-023 Package elevator_pkg SHALL hold N_FLOORS=8, FLOOR_W=3, state encoding and dir encoding.
REQ-024 Sub-module elevator_timer (clear, enable, terminal-count parameter, done flag) SHALL be instantiated twice (travel, door).

Verification (bench overrides TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-025 Reset; call_btn[3] one cycle -> pending 8'h08; floor_bin 1,2,3 at 4-cycle steps with moving_up; at 3 door_open 3 cycles, pending 8'h00, then IDLE.
REQ-026 Idle at 0; call_btn[0] -> door_open for 3 cycles, floor_bin stays 0, no moving_* pulse.
REQ-027 At floor 2 moving to 6; call_btn[4] and call_btn[1] -> stops at 4, then 6, then flips dir, moving_down to 1.
REQ-028 At floor 5 in DOOR_OPEN; overload high 10 cycles -> door_open for 10+3 cycles total after release; call_btn[5] mid-door restarts the 3-cycle count.
REQ-029 Reset pulsed mid-travel between 4 and 5 with pending 8'h81 -> next cycle floor_bin 0, IDLE, pending 8'h00, all status outputs 0.
REQ-030 Idle at 0 with call_btn = 8'hFF one cycle -> door at 0, then every floor 1..7 served in order, floor_bin never exceeds 7.
